// File: rtl/mul_pkg.sv
// Shared types and size derivations for the iterative radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StAdd,
    StDone
  } state_e;

  typedef enum logic [2:0] {
    BoothZero,
    BoothPos1,
    BoothPos2,
    BoothNeg1,
    BoothNeg2
  } booth_sel_e;

  function automatic int unsigned acc_width(input int unsigned dw);
    return 2 * dw + 4;
  endfunction

  function automatic int unsigned booth_steps(input int unsigned dw);
    return (dw + 2) / 2;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] trip);
    booth_sel_e sel;
    case (trip)
      3'b001, 3'b010: sel = BoothPos1;
      3'b011:         sel = BoothPos2;
      3'b100:         sel = BoothNeg2;
      3'b101, 3'b110: sel = BoothNeg1;
      default:        sel = BoothZero;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/compressor_32.sv
// Generic 3:2 carry-save compressor; carry output is pre-shifted by one bit.
module compressor_32 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [DATA_WIDTH-1:0] c_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic [DATA_WIDTH-1:0] carry_o
);

  logic [DATA_WIDTH-1:0] maj;

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign maj     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign carry_o = {maj[DATA_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle into a
// carry-save accumulator, single carry-propagate add at the end.
module mul_booth_iter
  import mul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      a_signed,
  input  logic                      b_signed,
  input  logic [DATA_WIDTH-1:0]     data_a,
  input  logic [DATA_WIDTH-1:0]     data_b,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   product
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH);
  localparam int unsigned STEPS = booth_steps(DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(STEPS);

  state_e                  state_q;
  logic [ACC_W-1:0]        a_q;
  logic [DATA_WIDTH+1:0]   b_q;
  logic                    b_prev_q;
  logic [ACC_W-1:0]        sum_q, carry_q;
  logic [CNT_W-1:0]        step_q;
  logic [2*DATA_WIDTH-1:0] product_q;
  logic                    out_valid_q;

  booth_sel_e              sel;
  logic [ACC_W-1:0]        pp;
  logic [ACC_W-1:0]        sum_d, carry_d;
  logic [2*DATA_WIDTH-1:0] total;

  // a_q is the multiplicand already shifted by 2i, so pp needs no extra shift.
  assign sel = booth_decode({b_q[1:0], b_prev_q});

  always_comb begin
    pp = '0;
    unique case (sel)
      BoothZero: pp = '0;
      BoothPos1: pp = a_q;
      BoothPos2: pp = a_q << 1;
      BoothNeg1: pp = -a_q;
      BoothNeg2: pp = -(a_q << 1);
      default:   pp = '0;
    endcase
  end

  compressor_32 #(
    .DATA_WIDTH(ACC_W)
  ) u_csa (
    .a_i    (sum_q),
    .b_i    (carry_q),
    .c_i    (pp),
    .sum_o  (sum_d),
    .carry_o(carry_d)
  );

  assign total = sum_q[2*DATA_WIDTH-1:0] + carry_q[2*DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      b_prev_q    <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      step_q      <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= {{(ACC_W-DATA_WIDTH){a_signed & data_a[DATA_WIDTH-1]}}, data_a};
            b_q      <= {{2{b_signed & data_b[DATA_WIDTH-1]}}, data_b};
            b_prev_q <= 1'b0;
            sum_q    <= '0;
            carry_q  <= '0;
            step_q   <= '0;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          sum_q    <= sum_d;
          carry_q  <= carry_d;
          a_q      <= a_q << 2;
          b_q      <= b_q >> 2;
          b_prev_q <= b_q[1];
          step_q   <= step_q + 1'b1;
          if (step_q == CNT_W'(STEPS - 1)) state_q <= StAdd;
        end
        StAdd: begin
          product_q   <= total;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule

// File: tb/tb_mul_booth_iter.sv
// Directed and model-checked stimulus for mul_booth_iter at DATA_WIDTH=32.
module tb_mul_booth_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        a_signed = 1'b0;
  logic        b_signed = 1'b0;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] product;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_booth_iter #(
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .data_a   (data_a),
    .data_b   (data_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic as, input logic bs,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] ax, bx, p;
    ax = {{34{as & a[31]}}, a};
    bx = {{34{bs & b[31]}}, b};
    p  = ax * bx;
    return p[63:0];
  endfunction

  // Presents operands in an idle cycle; returns just after the accept edge.
  task automatic start_op(input logic as, input logic bs, input logic [31:0] a,
                          input logic [31:0] b);
    a_signed = as;
    b_signed = bs;
    data_a   = a;
    data_b   = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    data_a   = 32'hdead_beef;
    data_b   = 32'h1357_9bdf;
  endtask

  task automatic wait_valid(input string tag, input logic [63:0] exp);
    int n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd19);
    check({tag, " product"}, product, exp);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " back to idle"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic as, input logic bs,
                        input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    start_op(as, bs, a, b);
    wait_valid(tag, exp);
    finish_op(tag);
  endtask

  initial begin
    int seen;
    logic as, bs;
    logic [31:0] ra, rb;

    repeat (3) step();
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset product", product, 64'd0);
    rst = 1'b0;
    step();

    run_op("u 3x4", 1'b0, 1'b0, 32'd3, 32'd4, 64'h0000_0000_0000_000C);
    run_op("u ffx ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("s -1x-1", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op("s minxmin", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    run_op("su -1xff", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_op("us ffx-1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    run_op("s -3x5", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("u 0x max", 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 64'd0);

    // Backpressure: product and out_valid hold while out_ready is low.
    start_op(1'b0, 1'b0, 32'd100_000, 32'd300_000);
    wait_valid("hold", 64'd30_000_000_000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold out_valid", {63'd0, out_valid}, 64'd1);
      check("hold product", product, 64'd30_000_000_000);
      check("hold in_ready", {63'd0, in_ready}, 64'd0);
    end
    finish_op("hold");
    check("hold released out_valid", {63'd0, out_valid}, 64'd0);

    // Flush at CALC step 8 with a coincident in_valid that must be dropped.
    start_op(1'b0, 1'b0, 32'h1234, 32'h5678);
    repeat (8) step();
    flush    = 1'b1;
    in_valid = 1'b1;
    data_a   = 32'd9;
    data_b   = 32'd9;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush in_ready", {63'd0, in_ready}, 64'd1);
    check("flush out_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("flush no output", 64'(seen), 64'd0);
    run_op("after flush 7x6", 1'b0, 1'b0, 32'd7, 32'd6, 64'd42);

    // Reset mid-operation discards it and clears the product register.
    start_op(1'b0, 1'b0, 32'd11, 32'd13);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("midrst in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst product", product, 64'd0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    check("midrst no output", 64'(seen), 64'd0);
    run_op("after rst 7x6", 1'b0, 1'b0, 32'd7, 32'd6, 64'd42);

    for (int k = 0; k < 300; k++) begin
      as = 1'($urandom_range(0, 1));
      bs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (k % 16 == 0) ra = {ra[31], 31'd0};
      if (k % 16 == 1) rb = {32{rb[0]}};
      run_op("random", as, bs, ra, rb, ref_mul(as, bs, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
